sram_arbiter: RTL and testbench
===============================

# sram_arbiter

Round-robin arbiter sharing the single packet SRAM port among NUM_REQ requesters (parser, executor, deparser, ...). Each requester raises a request and owns the whole SRAM bus for as long as it holds the request. This makes multi-cycle sequences such as instruction fetch or checksum read-modify-write atomic. A hold watchdog revokes a grant that is held too long. The block sits between the pipeline engines and the SRAM controller and replaces their ad-hoc local SRAM muxes.

## Interface
- NUM_REQ, 3, number of requesters (2..8).
- MAX_HOLD, 1024, maximum cycles one grant may last; 0 disables the watchdog.
- clk  in  1  clock, all state on posedge.
- rst  in  1  asynchronous, active-low reset.
- req_i  in  NUM_REQ  per-requester bus request, level.
- ce_i  in  NUM_REQ  per-requester chip enable.
- we_i  in  NUM_REQ  per-requester write enable.
- addr_i  in  NUM_REQ*32  per-requester address; requester k uses bits [32k+31:32k].
- sel_i  in  NUM_REQ*4  per-requester byte select.
- wdata_i  in  NUM_REQ*32  per-requester write data.
- gnt_o  out  NUM_REQ  one-hot grant (all zero when idle).
- rdata_o  out  32  SRAM read data, broadcast to all requesters.
- timeout_o  out  1  one-cycle pulse when the watchdog revokes a grant.
- sram_ce_o, sram_we_o  out  1 each  to SRAM.
- sram_addr_o  out  32  to SRAM.
- sram_sel_o  out  4  to SRAM.
- sram_data_o  out  32  to SRAM.
- sram_data_i  in  32  from SRAM.

## Operation
- **Registered state**
  - owner: index of the current owner.
  - granted: flag, set while a grant is active.
  - last: index of the most recent grantee; reset value NUM_REQ-1, so requester 0 wins first.
  - hold_cnt: 32-bit grant-length counter.
  - blocked: one bit per requester.
- **State machine**
  - IDLE (granted=0): if any eligible req_i bit is set, grant the first eligible index scanning last+1, last+2, ... modulo NUM_REQ. Then set owner and last, clear hold_cnt, and go to GRANT.
  - GRANT: owner keeps the bus while req_i[owner]=1. hold_cnt increments and saturates at 2^32-1.
  - Release: when req_i[owner]=0, re-arbitrate in the same cycle among the other eligible requesters. The winner is granted at the next edge, or the block returns to IDLE if none is eligible.
  - Watchdog: when MAX_HOLD≠0 and hold_cnt reaches MAX_HOLD-1 while the request is still high, the grant is revoked at the next edge.
    - timeout_o pulses in that same cycle.
    - blocked[owner] is set.
    - Re-arbitration proceeds as on a release.
- **Eligibility:** a requester is eligible when req_i[k]=1 and blocked[k]=0. blocked[k] clears on any edge where req_i[k]=0.
- **Output mux**
  - Combinational, selected by owner, gated by granted and req_i[owner].
  - sram_ce_o = ce_i[owner] & req_i[owner] & granted.
  - sram_we_o is gated the same way.
  - addr, sel and data pass through from the owner, and are zero when not granted.
- **Read path:** rdata_o = sram_data_i, pure wire, no added latency. The SRAM's own read latency applies unchanged.
- **Simultaneous events:** a release and a new request arriving in the same cycle are resolved by the round-robin scan. The releasing owner is ineligible in its release cycle because its req_i bit is low.

## Timing
- Reset (rst=0, asynchronous):
  - gnt_o=0, timeout_o=0, granted=0, blocked=0, hold_cnt=0, last=NUM_REQ-1.
  - All sram_* outputs are 0.
  - rdata_o follows sram_data_i.
- Reset mid-grant: the grant drops immediately (asynchronously). After rst rises, arbitration restarts from requester 0.
- Grant latency: req_i sampled high at edge t gives gnt_o at t (registered, visible the cycle after the request is first driven). The requester must not drive ce_i before it sees gnt_o.
- Handover: owner drops req in cycle c. At edge c+1 gnt_o moves to the new winner, so there is no idle bus cycle. Owner signals are gated off during cycle c.
- Watchdog: with MAX_HOLD=M, a continuously held grant lasts exactly M cycles. timeout_o is high for the one cycle after the revoking edge, aligned with the new gnt_o.
- gnt_o is always one-hot or zero, and never changes except on a clk edge or on async reset.

## Test plan
- **Single requester.** Stimulus: req_i=3'b010, ce_i[1]=1, we_i[1]=0, addr_i[1]=0x10. Required: gnt_o=3'b010 from the next edge; sram_addr_o=0x10 and sram_ce_o=1 while granted. Then req low gives gnt_o=0 and sram_ce_o=0 at the next edge.
- **Round-robin fairness.** Stimulus: all three requesters request continuously, each holding for 4 cycles after grant and then dropping for 1 cycle. Required: grant order 0,1,2,0,1,2 with back-to-back handover and no idle cycle.
- **Atomic hold.** Stimulus: requester 1 holds for 20 cycles while 0 and 2 request. Required: gnt_o stays 3'b010 for all 20 cycles; next grant goes to 2, then 0.
- **Watchdog.** Stimulus: MAX_HOLD=8, requester 0 holds forever, requester 2 requests. Required: gnt_o=3'b001 for 8 cycles, then timeout_o one cycle and gnt_o=3'b100. Requester 0 is not regranted until it drops req for at least one cycle.
- **Async reset mid-grant.** Stimulus: rst low during an active write by requester 2. Required: gnt_o=0 and sram_ce_o=sram_we_o=0 without waiting for a clk edge. After release with all req high, the first grant is requester 0.

Source files
------------

// File: rtl/sram_arbiter.sv
// Round-robin arbiter granting exclusive use of the packet SRAM port to one
// requester for as long as it holds its request, with a hold-time watchdog.
module sram_arbiter #(
  parameter int unsigned NUM_REQ  = 3,
  parameter int unsigned MAX_HOLD = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_i,
  input  logic [NUM_REQ-1:0]      ce_i,
  input  logic [NUM_REQ-1:0]      we_i,
  input  logic [NUM_REQ*32-1:0]   addr_i,
  input  logic [NUM_REQ*4-1:0]    sel_i,
  input  logic [NUM_REQ*32-1:0]   wdata_i,
  output logic [NUM_REQ-1:0]      gnt_o,
  output logic [31:0]             rdata_o,
  output logic                    timeout_o,
  output logic                    sram_ce_o,
  output logic                    sram_we_o,
  output logic [31:0]             sram_addr_o,
  output logic [3:0]              sram_sel_o,
  output logic [31:0]             sram_data_o,
  input  logic [31:0]             sram_data_i
);

  localparam int unsigned IW       = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;
  localparam logic [31:0] HOLD_LIM = (MAX_HOLD == 0) ? '0 : 32'(MAX_HOLD - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t               state;
  logic [IW-1:0]        owner;
  logic [IW-1:0]        last;
  logic [31:0]          hold_cnt;
  logic [NUM_REQ-1:0]   blocked;

  logic                 granted;
  logic [NUM_REQ-1:0]   owner_oh;
  logic                 own_req, own_ce, own_we;
  logic [31:0]          own_addr, own_wdata;
  logic [3:0]           own_sel;
  logic                 active, release_c, wd_fire;
  logic [NUM_REQ-1:0]   cand;
  logic                 found;
  logic [IW-1:0]        pick;

  assign granted = (state == GRANT);

  always_comb begin
    owner_oh  = '0;
    own_req   = 1'b0;
    own_ce    = 1'b0;
    own_we    = 1'b0;
    own_addr  = '0;
    own_sel   = '0;
    own_wdata = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (owner == IW'(k)) begin
        owner_oh[k] = 1'b1;
        own_req     = req_i[k];
        own_ce      = ce_i[k];
        own_we      = we_i[k];
        own_addr    = addr_i[32*k +: 32];
        own_sel     = sel_i[4*k +: 4];
        own_wdata   = wdata_i[32*k +: 32];
      end
    end
  end

  assign active      = granted & own_req;
  assign release_c   = granted & ~own_req;
  assign wd_fire     = active && (MAX_HOLD != 0) && (hold_cnt == HOLD_LIM);

  assign gnt_o       = granted ? owner_oh : '0;
  assign rdata_o     = sram_data_i;
  assign sram_ce_o   = own_ce & active;
  assign sram_we_o   = own_we & active;
  assign sram_addr_o = active ? own_addr  : '0;
  assign sram_sel_o  = active ? own_sel   : '0;
  assign sram_data_o = active ? own_wdata : '0;

  // The current owner is never a candidate: on release its request is low,
  // on watchdog revocation it becomes blocked at the same edge.
  assign cand = req_i & ~blocked & ~(granted ? owner_oh : '0);

  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        if (!found && cand[k] && ((32'(last) + i) % NUM_REQ == k)) begin
          found = 1'b1;
          pick  = IW'(k);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      owner     <= '0;
      last      <= IW'(NUM_REQ - 1);
      hold_cnt  <= '0;
      blocked   <= '0;
      timeout_o <= 1'b0;
    end else begin
      timeout_o <= wd_fire;
      blocked   <= (blocked & req_i) | (wd_fire ? owner_oh : '0);
      if (!granted || release_c || wd_fire) begin
        if (found) begin
          state    <= GRANT;
          owner    <= pick;
          last     <= pick;
          hold_cnt <= '0;
        end else begin
          state <= IDLE;
        end
      end else if (hold_cnt != '1) begin
        hold_cnt <= hold_cnt + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed test of sram_arbiter: reset, single requester, round-robin
// handover, atomic hold, watchdog revocation and asynchronous reset.
module tb_sram_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic [2:0]   req, ce, we;
  logic [95:0]  addr, wdata;
  logic [11:0]  sel;
  logic [31:0]  sram_rd;

  logic [2:0]   gnt, gnt_wd;
  logic [31:0]  rdata, rdata_wd;
  logic         tmo, tmo_wd;
  logic         s_ce, s_we, s_ce_wd, s_we_wd;
  logic [31:0]  s_addr, s_data, s_addr_wd, s_data_wd;
  logic [3:0]   s_sel, s_sel_wd;

  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0] exp_addr [3];

  always #5 clk = ~clk;

  sram_arbiter #(.NUM_REQ(3), .MAX_HOLD(1024)) dut (
    .clk(clk), .rst(rst), .req_i(req), .ce_i(ce), .we_i(we),
    .addr_i(addr), .sel_i(sel), .wdata_i(wdata),
    .gnt_o(gnt), .rdata_o(rdata), .timeout_o(tmo),
    .sram_ce_o(s_ce), .sram_we_o(s_we), .sram_addr_o(s_addr),
    .sram_sel_o(s_sel), .sram_data_o(s_data), .sram_data_i(sram_rd)
  );

  sram_arbiter #(.NUM_REQ(3), .MAX_HOLD(8)) dut_wd (
    .clk(clk), .rst(rst), .req_i(req), .ce_i(ce), .we_i(we),
    .addr_i(addr), .sel_i(sel), .wdata_i(wdata),
    .gnt_o(gnt_wd), .rdata_o(rdata_wd), .timeout_o(tmo_wd),
    .sram_ce_o(s_ce_wd), .sram_we_o(s_we_wd), .sram_addr_o(s_addr_wd),
    .sram_sel_o(s_sel_wd), .sram_data_o(s_data_wd), .sram_data_i(sram_rd)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    exp_addr[0] = 32'h100;
    exp_addr[1] = 32'h10;
    exp_addr[2] = 32'h2000;
    rst = 1'b0; req = '0; ce = '0; we = '0;
    addr  = {32'h2000, 32'h10, 32'h100};
    sel   = {4'h3, 4'hF, 4'h1};
    wdata = {32'hD2, 32'hD1, 32'hD0};
    sram_rd = 32'hA5A5_0001;

    // Reset state
    #3;
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_tmo", 32'(tmo), 0);
    chk("rst_ce", 32'(s_ce), 0);
    chk("rst_we", 32'(s_we), 0);
    chk("rst_addr", s_addr, 0);
    chk("rst_sel", 32'(s_sel), 0);
    chk("rst_data", s_data, 0);
    chk("rst_rdata", rdata, 32'hA5A5_0001);
    cyc();
    rst = 1'b1;

    // Single requester
    req = 3'b010; ce = 3'b010;
    #1;
    chk("single_pre_gnt", 32'(gnt), 0);
    cyc();
    chk("single_gnt", 32'(gnt), 32'h2);
    chk("single_ce", 32'(s_ce), 1);
    chk("single_we", 32'(s_we), 0);
    chk("single_addr", s_addr, 32'h10);
    chk("single_sel", 32'(s_sel), 32'hF);
    chk("single_data", s_data, 32'hD1);
    sram_rd = 32'h1234_5678;
    cyc();
    chk("single_gnt2", 32'(gnt), 32'h2);
    chk("single_rdata", rdata, 32'h1234_5678);
    req = '0; ce = '0;
    #1;
    chk("single_drop_ce", 32'(s_ce), 0);
    chk("single_drop_addr", s_addr, 0);
    chk("single_drop_gnt", 32'(gnt), 32'h2);
    cyc();
    chk("single_idle_gnt", 32'(gnt), 0);

    // Round-robin fairness
    rst = 1'b0;
    #1;
    req = 3'b111; ce = 3'b111;
    cyc();
    rst = 1'b1;
    cyc();
    for (int g = 0; g < 6; g++) begin
      #1;
      for (int j = 0; j < 4; j++) begin
        chk("rr_gnt", 32'(gnt), 32'(1 << (g % 3)));
        chk("rr_addr", s_addr, exp_addr[g % 3]);
        chk("rr_ce", 32'(s_ce), 1);
        cyc();
      end
      req[g % 3] = 1'b0;
      #1;
      chk("rr_rel_gnt", 32'(gnt), 32'(1 << (g % 3)));
      chk("rr_rel_ce", 32'(s_ce), 0);
      cyc();
      req[g % 3] = 1'b1;
    end

    // Atomic hold by requester 1
    rst = 1'b0;
    #1;
    rst = 1'b1;
    req = 3'b010;
    cyc();
    req = 3'b111;
    #1;
    for (int i = 0; i < 20; i++) begin
      chk("hold_gnt", 32'(gnt), 32'h2);
      cyc();
    end
    req[1] = 1'b0;
    #1;
    chk("hold_rel_gnt", 32'(gnt), 32'h2);
    cyc();
    chk("hold_next2", 32'(gnt), 32'h4);
    req[2] = 1'b0;
    cyc();
    chk("hold_next0", 32'(gnt), 32'h1);

    // Watchdog (MAX_HOLD=8 instance)
    rst = 1'b0;
    #1;
    rst = 1'b1;
    req = 3'b101;
    cyc();
    for (int i = 0; i < 8; i++) begin
      chk("wd_gnt0", 32'(gnt_wd), 32'h1);
      chk("wd_tmo_low", 32'(tmo_wd), 0);
      cyc();
    end
    chk("wd_gnt2", 32'(gnt_wd), 32'h4);
    chk("wd_tmo_pulse", 32'(tmo_wd), 1);
    cyc();
    chk("wd_tmo_end", 32'(tmo_wd), 0);
    chk("wd_gnt2_hold", 32'(gnt_wd), 32'h4);
    req[2] = 1'b0;
    cyc();
    chk("wd_blocked1", 32'(gnt_wd), 0);
    cyc();
    chk("wd_blocked2", 32'(gnt_wd), 0);
    req[0] = 1'b0;
    cyc();
    chk("wd_dropped", 32'(gnt_wd), 0);
    req[0] = 1'b1;
    cyc();
    chk("wd_regrant0", 32'(gnt_wd), 32'h1);

    // Asynchronous reset during a write by requester 2
    rst = 1'b0;
    #1;
    rst = 1'b1;
    req = 3'b100; ce = 3'b100; we = 3'b100;
    cyc();
    chk("ar_gnt", 32'(gnt), 32'h4);
    chk("ar_ce", 32'(s_ce), 1);
    chk("ar_we", 32'(s_we), 1);
    chk("ar_addr", s_addr, 32'h2000);
    chk("ar_data", s_data, 32'hD2);
    #2;
    rst = 1'b0;
    #1;
    chk("ar_async_gnt", 32'(gnt), 0);
    chk("ar_async_ce", 32'(s_ce), 0);
    chk("ar_async_we", 32'(s_we), 0);
    chk("ar_async_addr", s_addr, 0);
    req = 3'b111; ce = 3'b111;
    cyc();
    rst = 1'b1;
    cyc();
    chk("ar_first_gnt", 32'(gnt), 32'h1);
    chk("ar_first_we", 32'(s_we), 0);
    chk("ar_first_addr", s_addr, 32'h100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
